cpu7_icu: RTL

Instruction-cache-side responder for the fetch request/response interface driven by the IFU fetch datapath. Accepts one 64-bit-aligned fetch request at a time from the IFU, issues it to the instruction memory port, and returns the 64-bit fetch line. It also honours IFU cancels, including a stale memory response already in flight. Sits between `cpu7_ifu` and the instruction SRAM/bus bridge.

---
 rtl/cpu7_icu.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cpu7_icu.sv
// rtl/cpu7_icu.sv - instruction-cache-side fetch responder between cpu7_ifu and the instruction memory port
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   ifu_icu_req_ic1/addr_ic1         fetch request and address from the IFU (addr[2:0] ignored)
//   icu_ifu_ack_ic1                  request accepted this cycle (combinational)
//   ifu_icu_cancel                   abandon the outstanding request
//   icu_ifu_data_ic2/data_valid_ic2  64-bit fetch line and its valid pulse
//   icu_mem_req/icu_mem_addr         registered memory read request and line address
//   mem_icu_addr_ok/data_ok/rdata    memory address handshake and in-order read response
module cpu7_icu (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ifu_icu_req_ic1,
  input  logic [31:0] ifu_icu_addr_ic1,
  output logic        icu_ifu_ack_ic1,
  input  logic        ifu_icu_cancel,
  output logic [63:0] icu_ifu_data_ic2,
  output logic        icu_ifu_data_valid_ic2,
  output logic        icu_mem_req,
  output logic [31:0] icu_mem_addr,
  input  logic        mem_icu_addr_ok,
  input  logic        mem_icu_data_ok,
  input  logic [63:0] mem_icu_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  logic [1:0]  st, st_n;
  logic [31:3] addr_q, addr_n;
  logic        pend_vld, pend_vld_n;
  logic [31:3] pend_addr, pend_addr_n;
  logic        mem_req_q;

  // Fetch lines are 8-byte aligned, so the low address bits carry no information.
  logic        unused_addr_lo;
  assign unused_addr_lo = ^ifu_icu_addr_ic1[2:0];

  // In DROP, a cancel arriving this cycle supersedes whatever refetch was stored.
  logic        eff_vld;
  logic [31:3] eff_addr;
  assign eff_vld  = ifu_icu_cancel ? ifu_icu_req_ic1 : pend_vld;
  assign eff_addr = ifu_icu_cancel ? ifu_icu_addr_ic1[31:3] : pend_addr;

  assign icu_ifu_ack_ic1        = ifu_icu_req_ic1 & ((st == ST_IDLE) | ifu_icu_cancel);
  assign icu_ifu_data_valid_ic2 = (st == ST_DATA) & mem_icu_data_ok & ~ifu_icu_cancel;
  assign icu_ifu_data_ic2       = mem_icu_rdata;
  assign icu_mem_req            = mem_req_q;
  assign icu_mem_addr           = {addr_q, 3'b000};

  always_comb begin
    st_n        = st;
    addr_n      = addr_q;
    pend_vld_n  = pend_vld;
    pend_addr_n = pend_addr;
    case (st)
      ST_IDLE: begin
        if (ifu_icu_req_ic1) begin
          st_n   = ST_ADDR;
          addr_n = ifu_icu_addr_ic1[31:3];
        end
      end
      ST_ADDR: begin
        if (ifu_icu_cancel) begin
          if (mem_icu_addr_ok) begin
            // Address already taken by memory: its response is still owed.
            st_n        = ST_DROP;
            pend_vld_n  = ifu_icu_req_ic1;
            pend_addr_n = ifu_icu_addr_ic1[31:3];
          end else if (ifu_icu_req_ic1) begin
            // Memory never sampled the old address, so swap it in place.
            addr_n = ifu_icu_addr_ic1[31:3];
          end else begin
            st_n = ST_IDLE;
          end
        end else if (mem_icu_addr_ok) begin
          st_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (ifu_icu_cancel) begin
          if (mem_icu_data_ok) begin
            if (ifu_icu_req_ic1) begin
              st_n   = ST_ADDR;
              addr_n = ifu_icu_addr_ic1[31:3];
            end else begin
              st_n = ST_IDLE;
            end
          end else begin
            st_n        = ST_DROP;
            pend_vld_n  = ifu_icu_req_ic1;
            pend_addr_n = ifu_icu_addr_ic1[31:3];
          end
        end else if (mem_icu_data_ok) begin
          st_n = ST_IDLE;
        end
      end
      default: begin
        if (ifu_icu_cancel) begin
          pend_vld_n  = ifu_icu_req_ic1;
          pend_addr_n = ifu_icu_addr_ic1[31:3];
        end
        if (mem_icu_data_ok) begin
          pend_vld_n = 1'b0;
          if (eff_vld) begin
            st_n   = ST_ADDR;
            addr_n = eff_addr;
          end else begin
            st_n = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st        <= ST_IDLE;
      addr_q    <= '0;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      mem_req_q <= 1'b0;
    end else begin
      st        <= st_n;
      addr_q    <= addr_n;
      pend_vld  <= pend_vld_n;
      pend_addr <= pend_addr_n;
      mem_req_q <= (st_n == ST_ADDR);
    end
  end

endmodule
